// File: rtl/util_tx_timestamp_gate_pkg.sv
// Shared types and timestamp arithmetic for the timestamp-scheduled TX gate.
// The difference helper is wrap-safe for any timestamp width up to 64 bits.
package util_tx_timestamp_gate_pkg;

    localparam int unsigned TS_MAX_WIDTH = 64;
    localparam int unsigned STAT_WIDTH   = 32;

    typedef enum logic [2:0] {
        IDLE,
        PASS_ALL,
        EXPECT_TS,
        WAIT,
        PASS,
        DROP
    } gate_state_t;

    typedef enum logic [1:0] {
        ON_TIME,
        EARLY,
        LATE
    } ts_class_t;

    // Difference is taken modulo 2^tw, then sign-extended from bit tw-1.
    function automatic logic signed [63:0] ts_diff(
        input logic [63:0] ts,
        input logic [63:0] t,
        input int unsigned tw
    );
        logic [63:0] raw;
        raw = (ts - t) << (TS_MAX_WIDTH - tw);
        return $signed(raw) >>> (TS_MAX_WIDTH - tw);
    endfunction

    function automatic ts_class_t ts_classify(
        input logic signed [63:0] d
    );
        ts_class_t res;
        if (d == 64'sd1) begin
            res = ON_TIME;
        end else if (d > 64'sd1) begin
            res = EARLY;
        end else begin
            res = LATE;
        end
        return res;
    endfunction

endpackage

// File: rtl/util_tx_timestamp_gate_oreg.sv
// One-stage valid/ready output register; data holds while stalled.
module util_tx_timestamp_gate_oreg #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_load,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_load) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/util_tx_timestamp_gate.sv
// Holds timestamped sample groups until their start time; flags late ones.
// Define UTIL_TX_TIMESTAMP_GATE_STATS_EN for late/early event counters.
module util_tx_timestamp_gate
    import util_tx_timestamp_gate_pkg::*;
#(
    parameter int unsigned NUM_OF_CHANNELS   = 4,
    parameter int unsigned SAMPLE_DATA_WIDTH = 16,
    parameter int unsigned TIMESTAMP_WIDTH   = 64,
    parameter int unsigned EVERY_WIDTH       = 32,
    parameter int unsigned LATE_DROP         = 1
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [TIMESTAMP_WIDTH-1:0]                   timestamp,
    input  logic [EVERY_WIDTH-1:0]                       timestamp_every,
    input  logic                                         s_axis_xfer_req,
    input  logic                                         s_axis_valid,
    output logic                                         s_axis_ready,
    input  logic [NUM_OF_CHANNELS*SAMPLE_DATA_WIDTH-1:0] s_axis_data,
    output logic                                         m_axis_valid,
    input  logic                                         m_axis_ready,
    output logic [NUM_OF_CHANNELS*SAMPLE_DATA_WIDTH-1:0] m_axis_data,
    output logic                                         late_strobe,
    output logic                                         waiting
`ifdef UTIL_TX_TIMESTAMP_GATE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]                        late_count,
    output logic [STAT_WIDTH-1:0]                        early_count
`endif
);

    localparam int unsigned DW = NUM_OF_CHANNELS * SAMPLE_DATA_WIDTH;
    localparam int unsigned TW = TIMESTAMP_WIDTH;
    localparam int unsigned EW = EVERY_WIDTH;
    localparam logic [TW-1:0] TS_ONE = TW'(1);
    localparam logic [EW-1:0] EV_ONE = EW'(1);

    gate_state_t state_q;
    gate_state_t state_d;

    logic [EW-1:0]   every_q;
    logic [EW-1:0]   every_d;
    logic [EW-1:0]   cnt_q;
    logic [EW-1:0]   cnt_d;
    logic [TW-1:0]   ts_q;
    logic [TW-1:0]   ts_d;
    logic            late_q;
    logic            late_d;
    logic            load;
    logic            accept;
    logic            oreg_ready;
    logic [63:0]     ts_word64;
    logic [63:0]     now64;
    logic signed [63:0] diff;
    ts_class_t       cls;

    assign ts_word64 = 64'(s_axis_data[TW-1:0]);
    assign now64     = 64'(timestamp);
    assign diff      = ts_diff(ts_word64, now64, TW);
    assign cls       = ts_classify(diff);

    assign accept      = s_axis_valid & s_axis_ready;
    assign late_strobe = late_q;
    assign waiting     = (state_q == WAIT);

    // Ready is held off while late_strobe is up so the strobe never
    // coincides with a data word of the late group.
    always_comb begin
        s_axis_ready = 1'b0;
        unique case (state_q)
            PASS_ALL:  s_axis_ready = s_axis_xfer_req & oreg_ready;
            PASS:      s_axis_ready = s_axis_xfer_req & oreg_ready & ~late_q;
            EXPECT_TS: s_axis_ready = s_axis_xfer_req;
            DROP:      s_axis_ready = s_axis_xfer_req & ~late_q;
            default:   s_axis_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        every_d = every_q;
        cnt_d   = cnt_q;
        ts_d    = ts_q;
        late_d  = 1'b0;
        load    = 1'b0;
        if (!s_axis_xfer_req) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    every_d = timestamp_every;
                    cnt_d   = '0;
                    state_d = (timestamp_every == '0) ? PASS_ALL : EXPECT_TS;
                end
                PASS_ALL: begin
                    load = accept;
                end
                EXPECT_TS: begin
                    if (accept) begin
                        ts_d = s_axis_data[TW-1:0];
                        unique case (cls)
                            ON_TIME: state_d = PASS;
                            EARLY:   state_d = WAIT;
                            default: begin
                                late_d  = 1'b1;
                                state_d = (LATE_DROP != 0) ? DROP : PASS;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    // Release one cycle ahead so the first word lands at ts.
                    if (timestamp == ts_q - TS_ONE) begin
                        state_d = PASS;
                    end
                end
                PASS, DROP: begin
                    load = accept & (state_q == PASS);
                    if (accept) begin
                        if (cnt_q == every_q - EV_ONE) begin
                            cnt_d   = '0;
                            state_d = EXPECT_TS;
                        end else begin
                            cnt_d = cnt_q + EV_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            every_q <= '0;
            cnt_q   <= '0;
            ts_q    <= '0;
            late_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            every_q <= every_d;
            cnt_q   <= cnt_d;
            ts_q    <= ts_d;
            late_q  <= late_d;
        end
    end

    util_tx_timestamp_gate_oreg #(
        .DW(DW)
    ) u_oreg (
        .clk      (clk),
        .reset    (reset),
        .in_load  (load),
        .in_data  (s_axis_data),
        .in_ready (oreg_ready),
        .out_valid(m_axis_valid),
        .out_ready(m_axis_ready),
        .out_data (m_axis_data)
    );

`ifdef UTIL_TX_TIMESTAMP_GATE_STATS_EN
    logic                  xfer_q;
    logic                  late_evt;
    logic                  early_evt;
    logic [STAT_WIDTH-1:0] late_cnt_q;
    logic [STAT_WIDTH-1:0] early_cnt_q;

    assign late_evt  = (state_q == EXPECT_TS) & accept & (cls == LATE);
    assign early_evt = (state_q == EXPECT_TS) & accept & (cls == EARLY);

    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_q      <= 1'b0;
            late_cnt_q  <= '0;
            early_cnt_q <= '0;
        end else begin
            xfer_q <= s_axis_xfer_req;
            if (s_axis_xfer_req & ~xfer_q) begin
                late_cnt_q  <= '0;
                early_cnt_q <= '0;
            end else begin
                if (late_evt && late_cnt_q != '1) begin
                    late_cnt_q <= late_cnt_q + 1'b1;
                end
                if (early_evt && early_cnt_q != '1) begin
                    early_cnt_q <= early_cnt_q + 1'b1;
                end
            end
        end
    end

    assign late_count  = late_cnt_q;
    assign early_count = early_cnt_q;
`else
    // Event counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Directed bench: dut_a is the default build, dut_b uses TW=8 and LATE_DROP=0.
module tb_util_tx_timestamp_gate;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ts_cnt = '0;
    logic [31:0] every = '0;
    logic        xfer = 1'b0;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = '0;
    logic        m_ready = 1'b1;

    logic        a_s_ready, a_m_valid, a_late, a_wait;
    logic [63:0] a_m_data;
    logic        b_s_ready, b_m_valid, b_late, b_wait;
    logic [63:0] b_m_data;

    int total = 0;
    int bad = 0;

    int          cyc = 0;
    logic [63:0] a_out[$];
    logic [63:0] b_out[$];
    int          a_out_cyc[$];
    int          a_acc_cyc[$];
    logic [63:0] a_acc_ts[$];
    logic [63:0] b_acc_ts[$];
    int a_late_n, b_late_n, a_wait_n, b_wait_n, overlap_n;

    always #5 clk = ~clk;

    util_tx_timestamp_gate dut_a (
        .clk            (clk),
        .reset          (reset),
        .timestamp      (ts_cnt),
        .timestamp_every(every),
        .s_axis_xfer_req(xfer),
        .s_axis_valid   (s_valid),
        .s_axis_ready   (a_s_ready),
        .s_axis_data    (s_data),
        .m_axis_valid   (a_m_valid),
        .m_axis_ready   (m_ready),
        .m_axis_data    (a_m_data),
        .late_strobe    (a_late),
        .waiting        (a_wait)
    );

    util_tx_timestamp_gate #(
        .TIMESTAMP_WIDTH(8),
        .LATE_DROP      (0)
    ) dut_b (
        .clk            (clk),
        .reset          (reset),
        .timestamp      (ts_cnt[7:0]),
        .timestamp_every(every),
        .s_axis_xfer_req(xfer),
        .s_axis_valid   (s_valid),
        .s_axis_ready   (b_s_ready),
        .s_axis_data    (s_data),
        .m_axis_valid   (b_m_valid),
        .m_axis_ready   (m_ready),
        .m_axis_data    (b_m_data),
        .late_strobe    (b_late),
        .waiting        (b_wait)
    );

    always @(negedge clk) begin
        cyc++;
        if (s_valid && a_s_ready) begin
            a_acc_ts.push_back(ts_cnt);
            a_acc_cyc.push_back(cyc);
        end
        if (s_valid && b_s_ready) b_acc_ts.push_back(ts_cnt);
        if (a_m_valid && m_ready) begin
            a_out.push_back(a_m_data);
            a_out_cyc.push_back(cyc);
        end
        if (b_m_valid && m_ready) b_out.push_back(b_m_data);
        if (a_late) a_late_n++;
        if (b_late) b_late_n++;
        if (a_wait) a_wait_n++;
        if (b_wait) b_wait_n++;
        if ((a_late && s_valid && a_s_ready) ||
            (b_late && s_valid && b_s_ready)) overlap_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ts_cnt = ts_cnt + 1;
    endtask

    task automatic clear_mon();
        a_out.delete();
        b_out.delete();
        a_out_cyc.delete();
        a_acc_cyc.delete();
        a_acc_ts.delete();
        b_acc_ts.delete();
        a_late_n = 0;
        b_late_n = 0;
        a_wait_n = 0;
        b_wait_n = 0;
        overlap_n = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        xfer = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_mon();
    endtask

    task automatic start(input logic [31:0] e);
        every = e;
        xfer = 1'b1;
        tick();
    endtask

    task automatic send(input logic [63:0] w);
        int n;
        s_valid = 1'b1;
        s_data = w;
        n = 0;
        while (!a_s_ready && n < 200) begin
            tick();
            n++;
        end
        if (!a_s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: word %h never accepted", w);
        end
        tick();
        s_valid = 1'b0;
    endtask

    function automatic logic [63:0] ramp(input int k);
        return {16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        xfer = 1'b1;
        s_valid = 1'b1;
        s_data = 64'h1;
        tick();
        tick();
        total++;
        if (a_m_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_m_valid: got %b want 0", a_m_valid);
        end
        total++;
        if (a_m_data !== 64'h0) begin
            bad++;
            $display("FAIL reset_m_data: got %h want 0", a_m_data);
        end
        total++;
        if (a_s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_s_ready: got %b want 0", a_s_ready);
        end
        total++;
        if ({a_late, a_wait} !== 2'b00) begin
            bad++;
            $display("FAIL reset_late_wait: got %b want 00", {a_late, a_wait});
        end
        total++;
        if ({b_m_valid, b_s_ready, b_late, b_wait} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_b_outs: got %b want 0000",
                     {b_m_valid, b_s_ready, b_late, b_wait});
        end
        s_valid = 1'b0;
    endtask

    task automatic test_pass_through();
        do_reset();
        start(32'd0);
        for (int k = 0; k < 12; k++) send(ramp(k));
        tick();
        tick();
        total++;
        if (a_out.size() !== 12) begin
            bad++;
            $display("FAIL pass_count: got %0d want 12", a_out.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                total++;
                if (a_out[k] !== ramp(k)) begin
                    bad++;
                    $display("FAIL pass_data[%0d]: got %h want %h", k, a_out[k], ramp(k));
                end
                total++;
                if (a_out_cyc[k] !== a_acc_cyc[k] + 1) begin
                    bad++;
                    $display("FAIL pass_latency[%0d]: got %0d want 1", k,
                             a_out_cyc[k] - a_acc_cyc[k]);
                end
            end
        end
        total++;
        if (a_late_n !== 0) begin
            bad++;
            $display("FAIL pass_late: got %0d want 0", a_late_n);
        end
        xfer = 1'b0;
        tick();
    endtask

    task automatic test_on_time();
        logic [63:0] exp_ts[3];
        do_reset();
        start(32'd4);
        for (int g = 0; g < 3; g++) begin
            exp_ts[g] = ts_cnt + 1;
            send(exp_ts[g]);
            for (int k = 0; k < 4; k++) send(64'h100 + 64'(4*g + k));
        end
        tick();
        tick();
        total++;
        if (a_out.size() !== 12) begin
            bad++;
            $display("FAIL ontime_count: got %0d want 12", a_out.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                total++;
                if (a_out[i] !== 64'h100 + 64'(i)) begin
                    bad++;
                    $display("FAIL ontime_data[%0d]: got %h want %h", i, a_out[i],
                             64'h100 + 64'(i));
                end
            end
        end
        total++;
        if (a_acc_ts.size() !== 15) begin
            bad++;
            $display("FAIL ontime_accepts: got %0d want 15", a_acc_ts.size());
        end else begin
            for (int g = 0; g < 3; g++) begin
                for (int k = 0; k < 4; k++) begin
                    total++;
                    if (a_acc_ts[5*g+1+k] !== exp_ts[g] + 64'(k)) begin
                        bad++;
                        $display("FAIL ontime_accept_ts g%0d w%0d: got %h want %h", g, k,
                                 a_acc_ts[5*g+1+k], exp_ts[g] + 64'(k));
                    end
                end
            end
        end
        total++;
        if (a_wait_n !== 0 || a_late_n !== 0) begin
            bad++;
            $display("FAIL ontime_wait_late: got %0d/%0d want 0/0", a_wait_n, a_late_n);
        end
        xfer = 1'b0;
        tick();
    endtask

    task automatic test_early();
        logic [63:0] t0;
        do_reset();
        start(32'd4);
        t0 = ts_cnt;
        send(t0 + 5);
        for (int k = 0; k < 4; k++) send(64'h500 + 64'(k));
        tick();
        tick();
        total++;
        if (a_wait_n !== 4 || b_wait_n !== 4) begin
            bad++;
            $display("FAIL early_wait_cycles: got %0d/%0d want 4/4", a_wait_n, b_wait_n);
        end
        total++;
        if (a_acc_ts.size() < 2 || a_acc_ts[1] !== t0 + 5) begin
            bad++;
            $display("FAIL early_first_accept: got %h want %h",
                     (a_acc_ts.size() < 2) ? 64'hx : a_acc_ts[1], t0 + 5);
        end
        total++;
        if (a_out.size() !== 4) begin
            bad++;
            $display("FAIL early_count: got %0d want 4", a_out.size());
        end else begin
            total++;
            if (a_out[3] !== 64'h503 || a_out[0] !== 64'h500) begin
                bad++;
                $display("FAIL early_data: got %h..%h want 500..503", a_out[0], a_out[3]);
            end
        end
        total++;
        if (a_late_n !== 0) begin
            bad++;
            $display("FAIL early_late: got %0d want 0", a_late_n);
        end
        xfer = 1'b0;
        tick();
    endtask

    task automatic test_late();
        do_reset();
        start(32'd4);
        send(ts_cnt);
        for (int k = 0; k < 4; k++) send(64'h300 + 64'(k));
        send(ts_cnt + 1);
        for (int k = 0; k < 4; k++) send(64'h400 + 64'(k));
        tick();
        tick();
        total++;
        if (a_late_n !== 1 || b_late_n !== 1) begin
            bad++;
            $display("FAIL late_strobe_pulses: got %0d/%0d want 1/1", a_late_n, b_late_n);
        end
        total++;
        if (a_out.size() !== 4) begin
            bad++;
            $display("FAIL late_drop_count: got %0d want 4", a_out.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (a_out[k] !== 64'h400 + 64'(k)) begin
                    bad++;
                    $display("FAIL late_drop_data[%0d]: got %h want %h", k, a_out[k],
                             64'h400 + 64'(k));
                end
            end
        end
        total++;
        if (b_out.size() !== 8) begin
            bad++;
            $display("FAIL late_pass_count: got %0d want 8", b_out.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (b_out[k] !== 64'h300 + 64'(k) || b_out[k+4] !== 64'h400 + 64'(k)) begin
                    bad++;
                    $display("FAIL late_pass_data[%0d]: got %h/%h want %h/%h", k, b_out[k],
                             b_out[k+4], 64'h300 + 64'(k), 64'h400 + 64'(k));
                end
            end
        end
        total++;
        if (overlap_n !== 0) begin
            bad++;
            $display("FAIL late_overlap: got %0d want 0", overlap_n);
        end
        xfer = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        start(32'd4);
        ts_cnt = 64'hFE;
        send(64'h101);
        for (int k = 0; k < 4; k++) send(64'h600 + 64'(k));
        tick();
        tick();
        total++;
        if (a_wait_n !== 2 || b_wait_n !== 2) begin
            bad++;
            $display("FAIL wrap_wait_cycles: got %0d/%0d want 2/2", a_wait_n, b_wait_n);
        end
        total++;
        if (b_acc_ts.size() < 2 || b_acc_ts[1] !== 64'h101) begin
            bad++;
            $display("FAIL wrap_release_b: got %h want 101",
                     (b_acc_ts.size() < 2) ? 64'hx : b_acc_ts[1]);
        end
        total++;
        if (b_out.size() !== 4 || b_late_n !== 0) begin
            bad++;
            $display("FAIL wrap_b_out_late: got %0d/%0d want 4/0", b_out.size(), b_late_n);
        end
        total++;
        if (a_acc_ts.size() < 2 || a_acc_ts[1] !== 64'h101) begin
            bad++;
            $display("FAIL wrap_release_a: got %h want 101",
                     (a_acc_ts.size() < 2) ? 64'hx : a_acc_ts[1]);
        end
        xfer = 1'b0;
        tick();
    endtask

    task automatic test_xfer_abort();
        do_reset();
        m_ready = 1'b0;
        start(32'd1);
        send(ts_cnt + 1);
        send(64'hAA);
        send(ts_cnt + 10);
        tick();
        tick();
        xfer = 1'b0;
        tick();
        total++;
        if ({a_s_ready, a_wait} !== 2'b00) begin
            bad++;
            $display("FAIL abort_idle: got ready/wait %b want 00", {a_s_ready, a_wait});
        end
        tick();
        tick();
        tick();
        total++;
        if (a_m_valid !== 1'b1 || a_m_data !== 64'hAA) begin
            bad++;
            $display("FAIL abort_hold: got %b/%h want 1/aa", a_m_valid, a_m_data);
        end
        m_ready = 1'b1;
        tick();
        total++;
        if (a_m_valid !== 1'b0 || a_out.size() !== 1) begin
            bad++;
            $display("FAIL abort_drain: got valid %b count %0d want 0/1", a_m_valid,
                     a_out.size());
        end else begin
            total++;
            if (a_out[0] !== 64'hAA) begin
                bad++;
                $display("FAIL abort_drain_data: got %h want aa", a_out[0]);
            end
        end
        clear_mon();
        start(32'd4);
        total++;
        if (a_s_ready !== 1'b1 || a_wait !== 1'b0) begin
            bad++;
            $display("FAIL restart_expect_ts: got %b/%b want 1/0", a_s_ready, a_wait);
        end
        send(ts_cnt + 1);
        for (int k = 0; k < 4; k++) send(64'h700 + 64'(k));
        tick();
        tick();
        total++;
        if (a_out.size() !== 4 || a_late_n !== 0) begin
            bad++;
            $display("FAIL restart_group: got %0d/%0d want 4/0", a_out.size(), a_late_n);
        end else begin
            total++;
            if (a_out[0] !== 64'h700 || a_out[3] !== 64'h703) begin
                bad++;
                $display("FAIL restart_data: got %h..%h want 700..703", a_out[0], a_out[3]);
            end
        end
        xfer = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_on_time();
        test_early();
        test_late();
        test_wrap();
        test_xfer_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/util_tx_timestamp_gate.md
Name: util_tx_timestamp_gate

Overview:
- Timestamp-scheduled gate on the DMA→DAC sample stream. Sits between the TX DMA and the channel unpacker.
- Inputs carry a timestamp word ahead of every group of timestamp_every sample words. The gate holds each group until the free-running sample timestamp reaches the group's timestamp.
- Late groups are dropped or passed, per parameter, and always flagged.
- Successor to the fixed 4x16 timestamp upack: generic channel, sample and timestamp widths, plus a selectable late policy and a wait indicator.

Parameters:
- NUM_OF_CHANNELS, 4, channels per word.
- SAMPLE_DATA_WIDTH, 16, bits per sample. DW = NUM_OF_CHANNELS*SAMPLE_DATA_WIDTH.
- TIMESTAMP_WIDTH, 64, timestamp bits (TW). Must be <= DW; the timestamp word carries it in data[TW-1:0].
- EVERY_WIDTH, 32, width of timestamp_every and of the group counter.
- LATE_DROP, 1, late policy: 1 = discard the late group; 0 = pass the late group immediately.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- timestamp  in  TW  free-running sample counter, +1 per clk.
- timestamp_every  in  EVERY_WIDTH  data words per group; 0 = timestamping off. Sampled on transfer start.
- s_axis_xfer_req  in  1  transfer active.
- s_axis_valid  in  1
- s_axis_ready  out  1
- s_axis_data  in  DW
- m_axis_valid  out  1
- m_axis_ready  in  1
- m_axis_data  out  DW
- late_strobe  out  1  one-cycle pulse per late timestamp.
- waiting  out  1  high while holding an early group.

Behaviour:
- Reset: m_axis_valid=0, m_axis_data=0, s_axis_ready=0, late_strobe=0, waiting=0. State IDLE, group counter 0.
- States:
  - IDLE: ready=0. On xfer_req=1, latch every = timestamp_every. Go to PASS_ALL if every==0, else EXPECT_TS.
  - PASS_ALL: forward every word.
  - EXPECT_TS: ready=1. The accepted word is a timestamp; latch ts = data[TW-1:0].
  - WAIT: ready=0, waiting=1.
  - PASS: forward data words; count accepted words.
  - DROP: ready=1; discard words; count accepted words.
- Timestamp classification, on acceptance of the timestamp word, with t = timestamp in that cycle and d = signed(ts - t), TW-bit, wrap-safe:
  - d==1 → PASS next cycle (on time).
  - d>1 → WAIT. Leave WAIT for PASS in the cycle timestamp == ts-1.
  - d<=0 → late; late_strobe=1 next cycle. Go to DROP if LATE_DROP=1, else PASS.
  - d >= 2^(TW-1) is treated as late.
- Result of classification: the first data word of an on-time or early group is accepted from s_axis in the cycle timestamp == ts.
- Group counting:
  - PASS and DROP leave for EXPECT_TS on acceptance of the every-th data word.
  - The counter clears on that transition.
  - The counter wraps only at every.
- Output register, single stage:
  - ready(PASS/PASS_ALL) = xfer_req & (~m_axis_valid | m_axis_ready).
  - Accepted data appears on m_axis the next cycle (latency 1).
  - m_axis_data holds stable while valid & ~ready.
- xfer_req handling:
  - s_axis_ready is combinationally gated by xfer_req.
  - xfer_req=0 in any state → IDLE next cycle; counter cleared; any WAIT or DROP is abandoned.
  - A word already in the output register stays valid until consumed.
- Stall: m_axis_ready low during PASS delays acceptance. Scheduling is not re-evaluated and no drop occurs.
- Simultaneous events: if reset and xfer_req fall in the same cycle, reset wins. late_strobe never overlaps a data accept of the same group.

Optional Feature:
- Macro: UTIL_TX_TIMESTAMP_GATE_STATS_EN.
- With the macro:
  - Adds outputs late_count[31:0] and early_count[31:0].
  - Each is a saturating count of late and early (d>1) timestamps.
  - Both clear on reset and on xfer_req rising.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package util_tx_timestamp_gate_pkg holds:
  - the state enum (IDLE, PASS_ALL, EXPECT_TS, WAIT, PASS, DROP);
  - the classification enum (ON_TIME, EARLY, LATE);
  - a function computing the wrap-safe signed difference.
- Sub-module util_tx_timestamp_gate_oreg: a one-stage valid/ready output register.

Test Plan:
- Pass-through, every=0: 12 words of ramp data 1..48, m_axis_ready=1 → 12 words out in order, latency 1, late_strobe never high.
- On time, every=4: ts = t+1, then 4 data words → data accepted back-to-back, no wait cycles, waiting=0, group repeats 3 times.
- Early: ts = t+5 → waiting high 4 cycles; first data accepted in the cycle timestamp==ts; 4 words out.
- Late, LATE_DROP=1: ts = t → late_strobe one pulse; 4 words consumed, none output; the next on-time group passes. With LATE_DROP=0 the same stimulus passes all 4 words and still pulses late_strobe.
- Wrap: TW=8, t=0xFE, ts=0x01 → classified early (d=3), released at timestamp 0x01.
- xfer_req deasserted mid-WAIT, with m_axis_ready=0 holding one word → IDLE, the held word is preserved until consumed. A new transfer starts in EXPECT_TS.
